// File: rtl/ipsxe_fft_pkg.sv
// Shared constants for the FFT result path: default widths, tuser/tdata field offsets
// and the peak-tracker state encoding.
package ipsxe_fft_pkg;

   localparam int unsigned FFT_LOG2_LEN     = 11;
   localparam int unsigned FFT_IN_WIDTH     = 12;
   localparam int unsigned FFT_LANE_WIDTH   = 16;
   localparam int unsigned FFT_USER_WIDTH   = 24;
   localparam int unsigned PEAK_MIN_BIN_DEF = 1;

   localparam int unsigned LANE_RE_LSB      = 0;
   localparam int unsigned TUSER_IDX_LSB    = 0;
   localparam int unsigned TUSER_EXP_LSB    = 16;
   localparam int unsigned TUSER_EXP_WIDTH  = 8;
   localparam int unsigned PWR_OUT_WIDTH    = 32;

   typedef enum logic {
      PK_IDLE = 1'b0,
      PK_ACC  = 1'b1
   } pk_state_e;

   // Significant bits of re^2+im^2: two squares of 2*w bits each plus one carry bit.
   function automatic int unsigned pwr_width(input int unsigned in_width);
      return 2 * in_width + 1;
   endfunction

endpackage

// File: rtl/ipsxe_fft_pwr_calc.sv
// Three-stage |X|^2 pipeline: register operands, square both components, sum.
// Sideband (valid/last/user) travels alongside with the same delay; no beats are added or dropped.
module ipsxe_fft_pwr_calc
   import ipsxe_fft_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = FFT_IN_WIDTH,
   parameter int unsigned LANE_WIDTH = FFT_LANE_WIDTH,
   parameter int unsigned USER_WIDTH = FFT_USER_WIDTH,
   localparam int unsigned PWR_W     = pwr_width(IN_WIDTH)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    tvalid,
   input  logic [2*LANE_WIDTH-1:0] tdata,
   input  logic                    tlast,
   input  logic [USER_WIDTH-1:0]   tuser,
   output logic                    pwr_valid,
   output logic [PWR_W-1:0]        pwr_data,
   output logic                    pwr_last,
   output logic [USER_WIDTH-1:0]   pwr_user
);

   localparam int unsigned PROD_W = 2 * IN_WIDTH;

   logic signed [PROD_W-1:0] re_s1;
   logic signed [PROD_W-1:0] im_s1;
   logic signed [PROD_W-1:0] re_sq_s2;
   logic signed [PROD_W-1:0] im_sq_s2;
   logic                     valid_s1;
   logic                     valid_s2;
   logic                     last_s1;
   logic                     last_s2;
   logic [USER_WIDTH-1:0]    user_s1;
   logic [USER_WIDTH-1:0]    user_s2;

   // Lane padding above each component carries no information.
   logic unused_lane_bits;
   assign unused_lane_bits = ^{tdata[LANE_WIDTH-1:IN_WIDTH],
                               tdata[2*LANE_WIDTH-1:LANE_WIDTH+IN_WIDTH]};

   // Operands are sign-extended to the product width so the squares never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_s1  <= 1'b0;
         last_s1   <= 1'b0;
         user_s1   <= '0;
         re_s1     <= '0;
         im_s1     <= '0;
         valid_s2  <= 1'b0;
         last_s2   <= 1'b0;
         user_s2   <= '0;
         re_sq_s2  <= '0;
         im_sq_s2  <= '0;
         pwr_valid <= 1'b0;
         pwr_last  <= 1'b0;
         pwr_user  <= '0;
         pwr_data  <= '0;
      end else if (ce) begin
         valid_s1  <= tvalid;
         last_s1   <= tlast;
         user_s1   <= tuser;
         re_s1     <= PROD_W'($signed(tdata[LANE_RE_LSB +: IN_WIDTH]));
         im_s1     <= PROD_W'($signed(tdata[LANE_WIDTH +: IN_WIDTH]));

         valid_s2  <= valid_s1;
         last_s2   <= last_s1;
         user_s2   <= user_s1;
         re_sq_s2  <= re_s1 * re_s1;
         im_sq_s2  <= im_s1 * im_s1;

         pwr_valid <= valid_s2;
         pwr_last  <= last_s2;
         pwr_user  <= user_s2;
         pwr_data  <= PWR_W'($unsigned(re_sq_s2)) + PWR_W'($unsigned(im_sq_s2));
      end
   end

endmodule

// File: rtl/ipsxe_fft_pwr_peak.sv
// FFT result post-processing: |X|^2 stream plus per-frame strongest-bin report.
// The tracker watches the power pipeline output and reports one cycle after the frame's last beat.
module ipsxe_fft_pwr_peak
   import ipsxe_fft_pkg::*;
#(
   parameter int unsigned LOG2_FFT_LEN = FFT_LOG2_LEN,
   parameter int unsigned IN_WIDTH     = FFT_IN_WIDTH,
   parameter int unsigned LANE_WIDTH   = FFT_LANE_WIDTH,
   parameter int unsigned USER_WIDTH   = FFT_USER_WIDTH,
   parameter int unsigned PEAK_MIN_BIN = PEAK_MIN_BIN_DEF
)(
   input  logic                       i_aclk,
   input  logic                       i_areset,
   input  logic                       i_aclken,
   input  logic                       i_axi4s_data_tvalid,
   input  logic [2*LANE_WIDTH-1:0]    i_axi4s_data_tdata,
   input  logic                       i_axi4s_data_tlast,
   input  logic [USER_WIDTH-1:0]      i_axi4s_data_tuser,
   output logic                       o_pwr_tvalid,
   output logic [PWR_OUT_WIDTH-1:0]   o_pwr_tdata,
   output logic                       o_pwr_tlast,
   output logic [USER_WIDTH-1:0]      o_pwr_tuser,
   output logic                       o_peak_valid,
   output logic [LOG2_FFT_LEN-1:0]    o_peak_idx,
   output logic [PWR_OUT_WIDTH-1:0]   o_peak_pwr,
   output logic [TUSER_EXP_WIDTH-1:0] o_peak_exp,
   output logic                       o_frame_err
);

   localparam int unsigned PWR_W = pwr_width(IN_WIDTH);
   localparam logic [LOG2_FFT_LEN-1:0] MIN_IDX = LOG2_FFT_LEN'(PEAK_MIN_BIN);

   logic [PWR_W-1:0]           s3_pwr;
   logic [LOG2_FFT_LEN-1:0]    s3_idx;
   logic [TUSER_EXP_WIDTH-1:0] s3_exp;
   logic                       eligible;

   pk_state_e                  state;
   pk_state_e                  state_nxt;
   logic [LOG2_FFT_LEN-1:0]    best_idx;
   logic [LOG2_FFT_LEN-1:0]    best_idx_nxt;
   logic [PWR_W-1:0]           best_pwr;
   logic [PWR_W-1:0]           best_pwr_nxt;
   logic [TUSER_EXP_WIDTH-1:0] best_exp;
   logic [TUSER_EXP_WIDTH-1:0] best_exp_nxt;
   logic                       peak_valid_nxt;
   logic [LOG2_FFT_LEN-1:0]    peak_idx_nxt;
   logic [PWR_OUT_WIDTH-1:0]   peak_pwr_nxt;
   logic [TUSER_EXP_WIDTH-1:0] peak_exp_nxt;
   logic                       frame_err_nxt;

   ipsxe_fft_pwr_calc #(
      .IN_WIDTH   (IN_WIDTH),
      .LANE_WIDTH (LANE_WIDTH),
      .USER_WIDTH (USER_WIDTH)
   ) u_pwr_calc (
      .clk       (i_aclk),
      .rst       (i_areset),
      .ce        (i_aclken),
      .tvalid    (i_axi4s_data_tvalid),
      .tdata     (i_axi4s_data_tdata),
      .tlast     (i_axi4s_data_tlast),
      .tuser     (i_axi4s_data_tuser),
      .pwr_valid (o_pwr_tvalid),
      .pwr_data  (s3_pwr),
      .pwr_last  (o_pwr_tlast),
      .pwr_user  (o_pwr_tuser)
   );

   assign o_pwr_tdata = PWR_OUT_WIDTH'(s3_pwr);
   assign s3_idx      = o_pwr_tuser[TUSER_IDX_LSB +: LOG2_FFT_LEN];
   assign s3_exp      = o_pwr_tuser[TUSER_EXP_LSB +: TUSER_EXP_WIDTH];
   assign eligible    = (s3_idx >= MIN_IDX);

   // Tracker state, running best and registered report outputs.
   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         state        <= PK_IDLE;
         best_idx     <= '0;
         best_pwr     <= '0;
         best_exp     <= '0;
         o_peak_valid <= 1'b0;
         o_peak_idx   <= '0;
         o_peak_pwr   <= '0;
         o_peak_exp   <= '0;
         o_frame_err  <= 1'b0;
      end else if (i_aclken) begin
         state        <= state_nxt;
         best_idx     <= best_idx_nxt;
         best_pwr     <= best_pwr_nxt;
         best_exp     <= best_exp_nxt;
         o_peak_valid <= peak_valid_nxt;
         o_peak_idx   <= peak_idx_nxt;
         o_peak_pwr   <= peak_pwr_nxt;
         o_peak_exp   <= peak_exp_nxt;
         o_frame_err  <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      best_idx_nxt   = best_idx;
      best_pwr_nxt   = best_pwr;
      best_exp_nxt   = best_exp;
      peak_valid_nxt = 1'b0;
      peak_idx_nxt   = o_peak_idx;
      peak_pwr_nxt   = o_peak_pwr;
      peak_exp_nxt   = o_peak_exp;
      frame_err_nxt  = 1'b0;

      if (o_pwr_tvalid) begin
         // Index 0 while accumulating means the previous tlast was lost: restart on this beat.
         if (state == PK_IDLE || s3_idx == '0) begin
            frame_err_nxt = (state == PK_ACC);
            best_exp_nxt  = s3_exp;
            if (eligible) begin
               best_idx_nxt = s3_idx;
               best_pwr_nxt = s3_pwr;
            end else begin
               best_idx_nxt = MIN_IDX;
               best_pwr_nxt = '0;
            end
         end else if (eligible && s3_pwr > best_pwr) begin
            best_idx_nxt = s3_idx;
            best_pwr_nxt = s3_pwr;
         end

         // The last beat is folded in before the report is taken.
         if (o_pwr_tlast) begin
            peak_valid_nxt = 1'b1;
            peak_idx_nxt   = best_idx_nxt;
            peak_pwr_nxt   = PWR_OUT_WIDTH'(best_pwr_nxt);
            peak_exp_nxt   = best_exp_nxt;
            state_nxt      = PK_IDLE;
         end else begin
            state_nxt      = PK_ACC;
         end
      end
   end

endmodule
